// File: rtl/bs_mult_serial.sv
// Bit-serial multiplier. Operands arrive LSB-first. The product streams out LSB-first,
// one column per step, and a running column carry is kept between steps.
module bs_mult_serial #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_first,
  input  logic x_bit,
  input  logic y_bit,
  input  logic is_signed,
  output logic in_ready,
  output logic p_valid,
  output logic p_bit,
  output logic p_first,
  output logic p_last,
  output logic busy
);

  // state | meaning
  // IDLE  | waiting for an accepted in_first
  // LOAD  | accepting operand bits 1..WIDTH-1, stalls allowed
  // FLUSH | upper product columns, one per cycle, input ignored

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW);
  localparam int SW = $clog2(2 * PW) + 1;
  localparam int KW = SW - 1;
  localparam logic [CW-1:0] K_LOAD_END = CW'(WIDTH - 1);
  localparam logic [CW-1:0] K_LAST     = CW'(PW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, k;
  logic            step_en, first_step;
  logic [WIDTH-1:0] x_reg, y_reg, x_eff, y_eff;
  logic            sgn_reg, sgn;
  logic [KW-1:0]   carry_reg, carry_in;
  logic [PW-1:0]   x_ext, y_ext;
  logic [SW-1:0]   sum;

  assign in_ready = (state != FLUSH);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    step_en    = 1'b0;
    first_step = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_first) begin
          step_en    = 1'b1;
          first_step = 1'b1;
          cnt_nxt    = CW'(1);
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          step_en = 1'b1;
          if (in_first) begin
            // restart: the new bit becomes column 0 of a fresh frame
            first_step = 1'b1;
            cnt_nxt    = CW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == K_LOAD_END) state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        step_en = 1'b1;
        if (cnt == K_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column k of the product: sum of x_ext[i]*y_ext[k-i] over i <= k, plus the carry in.
  // Operand bits above the current column are still zero, so no masking is needed.
  always_comb begin
    k        = first_step ? '0 : cnt;
    x_eff    = first_step ? '0 : x_reg;
    y_eff    = first_step ? '0 : y_reg;
    sgn      = first_step ? is_signed : sgn_reg;
    carry_in = first_step ? '0 : carry_reg;
    if (step_en && (state != FLUSH)) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (k == CW'(i)) begin
          x_eff[i] = x_bit;
          y_eff[i] = y_bit;
        end
      end
    end
    x_ext = {{WIDTH{sgn & x_eff[WIDTH-1]}}, x_eff};
    y_ext = {{WIDTH{sgn & y_eff[WIDTH-1]}}, y_eff};
    sum   = SW'(carry_in);
    for (int i = 0; i < PW; i++) begin
      if (CW'(i) <= k) sum = sum + SW'(x_ext[i] & y_ext[k - CW'(i)]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      sgn_reg   <= 1'b0;
      carry_reg <= '0;
      p_valid   <= 1'b0;
      p_bit     <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
    end else begin
      if (step_en) begin
        x_reg     <= x_eff;
        y_reg     <= y_eff;
        sgn_reg   <= sgn;
        carry_reg <= sum[SW-1:1];
      end
      p_valid <= step_en;
      p_bit   <= step_en & sum[0];
      p_first <= step_en & first_step;
      p_last  <= step_en && (state == FLUSH) && (cnt == K_LAST);
    end
  end

endmodule
